// File: rtl/icache_line_refill.sv
// Blocking direct-mapped instruction cache with multi-word line refill,
// an uncached address window, full flush and hit/miss counters.
module icache_line_refill #(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int          INDEX_BITS     = 4,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [15:0] UNC_HI         = 16'h1c09,
  parameter int          CNT_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_inst,
  output logic              cpu_valid,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  // state    | meaning
  // IDLE     | lookup; hits answered same cycle
  // REFILL   | fetching line beats in order from word 0
  // UNCACHED | single-beat fetch that bypasses the array
  // RESP     | one-cycle return of the response register

  localparam int WO    = $clog2(WORDS_PER_LINE);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - WO - 2;

  typedef enum logic [1:0] {IDLE, REFILL, UNCACHED, RESP} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [DATA_W-1:0]     data_q [LINES*WORDS_PER_LINE];

  logic [WO-1:0]         beat_q;
  logic [WO-1:0]         req_word_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic [TAG_W-1:0]      rtag_q;
  logic [DATA_W-1:0]     resp_q;

  logic [WO-1:0]         a_word;
  logic [INDEX_BITS-1:0] a_index;
  logic [TAG_W-1:0]      a_tag;
  logic                  a_unc;
  logic                  a_hit;
  logic                  last_beat;
  logic                  do_hit;
  logic                  do_miss;

  assign a_word    = cpu_addr[WO+1:2];
  assign a_index   = cpu_addr[WO+INDEX_BITS+1:WO+2];
  assign a_tag     = cpu_addr[ADDR_W-1:WO+INDEX_BITS+2];
  assign a_unc     = (cpu_addr[ADDR_W-1:ADDR_W-16] == UNC_HI);
  assign a_hit     = valid_q[a_index] && (tag_q[a_index] == a_tag);
  assign last_beat = (beat_q == {WO{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_inst  = data_q[{a_index, a_word}];
    cpu_valid = 1'b0;
    cpu_stall = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    do_hit    = 1'b0;
    do_miss   = 1'b0;
    case (state)
      IDLE: begin
        // flush wins over any lookup presented in the same cycle
        if (flush) begin
          cpu_stall = 1'b1;
        end else if (cpu_req) begin
          if (a_unc) begin
            cpu_stall = 1'b1;
            state_nxt = UNCACHED;
          end else if (a_hit) begin
            cpu_valid = 1'b1;
            do_hit    = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            do_miss   = 1'b1;
            state_nxt = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req   = 1'b1;
        mem_addr  = {rtag_q, idx_q, beat_q, 2'b00};
        cpu_stall = 1'b1;
        if (mem_rvalid && last_beat) state_nxt = RESP;
      end
      UNCACHED: begin
        mem_req   = 1'b1;
        mem_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
        cpu_stall = 1'b1;
        if (mem_rvalid) state_nxt = RESP;
      end
      RESP: begin
        cpu_inst  = resp_q;
        cpu_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      beat_q     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && flush) valid_q <= '0;
      if (do_hit)  hit_count  <= hit_count + CNT_W'(1);
      if (do_miss) begin
        miss_count <= miss_count + CNT_W'(1);
        beat_q     <= '0;
      end
      if (state == REFILL && mem_rvalid) begin
        beat_q <= beat_q + WO'(1);
        if (last_beat) valid_q[idx_q] <= 1'b1;
      end
    end
  end

  // Array, tag and response storage need no reset: valid_q guards them.
  always_ff @(posedge clk) begin
    if (do_miss) begin
      idx_q      <= a_index;
      rtag_q     <= a_tag;
      req_word_q <= a_word;
    end
    if (state == REFILL && mem_rvalid) begin
      data_q[{idx_q, beat_q}] <= mem_rdata;
      if (beat_q == req_word_q) resp_q <= mem_rdata;
      if (last_beat) tag_q[idx_q] <= rtag_q;
    end
    if (state == UNCACHED && mem_rvalid) resp_q <= mem_rdata;
  end

endmodule

// File: tb/tb_icache_line_refill.sv
// Directed bench for icache_line_refill: memory responder model plus a
// scoreboard of expected instructions checked when cpu_valid appears.
module tb_icache_line_refill;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_inst;
  logic        cpu_valid;
  logic        cpu_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int fails  = 0;

  logic [31:0] sb[$];
  logic [31:0] addr_q[$];

  int wcnt       = 0;
  int wait_cur   = 0;
  int fixed_wait = 0;
  bit rand_wait  = 1'b0;
  bit spurious   = 1'b0;
  int beats      = 0;

  icache_line_refill dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_inst   (cpu_inst),
    .cpu_valid  (cpu_valid),
    .cpu_stall  (cpu_stall),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    logic [31:0] base;
    if (a[31:16] == 16'h1c09) return 32'hDEADBEEF;
    base = a[8] ? 32'hB0 : 32'hA0;
    return base + {30'b0, a[3:2]};
  endfunction

  // Memory: answers each outstanding beat after wait_cur cycles.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (reset) begin
      wcnt = 0;
    end else if (spurious) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5A5A5A5A;
    end else if (mem_req) begin
      if (wcnt >= wait_cur) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_model(mem_addr);
        addr_q.push_back(mem_addr);
        beats++;
        wcnt     = 0;
        wait_cur = rand_wait ? int'($urandom_range(0, 4)) : fixed_wait;
      end else begin
        wcnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_wait(input int w, input bit rnd);
    fixed_wait = w;
    rand_wait  = rnd;
    wait_cur   = rnd ? int'($urandom_range(0, 4)) : w;
    wcnt       = 0;
  endtask

  // Issues one fetch; lat < 0 skips the latency check. A hit leaves
  // cpu_req high so the following posedge is the one that counts it.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input int lat);
    int  n;
    bit  done;
    logic [31:0] e;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = a;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (cpu_valid) begin
        e = sb.pop_front();
        chk("inst", cpu_inst, e);
        chk("stall_at_valid", {31'b0, cpu_stall}, 32'd0);
        if (lat >= 0) chk("latency", n, lat);
        if (n == 0) chk("hit_no_mem_req", {31'b0, mem_req}, 32'd0);
        else        cpu_req = 1'b0;
        done = 1'b1;
      end else begin
        chk("stall_hold", {31'b0, cpu_stall}, 32'd1);
        n++;
      end
    end
    chk("fetch_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] reuse_addr [3];
    logic [31:0] reuse_data [3];
    int guard;

    reset    = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    set_wait(0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_valid", {31'b0, cpu_valid}, 32'd0);
    chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst_mem_req",   {31'b0, mem_req},   32'd0);
    chk("rst_mem_addr",  mem_addr,           32'd0);
    chk("rst_hits",      hit_count,          32'd0);
    chk("rst_misses",    miss_count,         32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // cold miss, zero-wait memory
    addr_q.delete();
    do_fetch(32'h0000_0048, 32'hA2, 5);
    chk("cold_beats", addr_q.size(), 32'd4);
    if (addr_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("cold_beat_addr", addr_q[i], 32'h40 + 32'(4 * i));
    chk("cold_misses", miss_count, 32'd1);

    // back-to-back hits on the refilled line
    reuse_addr = '{32'h40, 32'h44, 32'h4C};
    reuse_data = '{32'hA0, 32'hA1, 32'hA3};
    addr_q.delete();
    for (int i = 0; i < 3; i++) do_fetch(reuse_addr[i], reuse_data[i], 0);
    idle_cycle();
    @(negedge clk);
    chk("reuse_hits",  hit_count,      32'd3);
    chk("reuse_beats", addr_q.size(),  32'd0);

    // conflict eviction in index 4
    do_fetch(32'h0000_0140, 32'hB0, 5);
    do_fetch(32'h0000_0040, 32'hA0, 5);
    @(negedge clk);
    chk("conflict_misses", miss_count, 32'd3);

    // uncached window, 3 wait cycles, twice
    for (int r = 0; r < 2; r++) begin
      set_wait(3, 1'b0);
      addr_q.delete();
      do_fetch(32'h1c09_0010, 32'hDEADBEEF, 5);
      chk("unc_beats", addr_q.size(), 32'd1);
      if (addr_q.size() == 1) chk("unc_addr", addr_q[0], 32'h1c09_0010);
    end
    @(negedge clk);
    chk("unc_hits",   hit_count,  32'd3);
    chk("unc_misses", miss_count, 32'd3);

    // flush wins over a simultaneous lookup, then the line misses
    set_wait(0, 1'b0);
    @(posedge clk);
    #1;
    flush    = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 32'h40;
    @(negedge clk);
    chk("flush_valid", {31'b0, cpu_valid}, 32'd0);
    chk("flush_stall", {31'b0, cpu_stall}, 32'd1);
    do_fetch(32'h0000_0040, 32'hA0, 5);
    @(negedge clk);
    chk("flush_hits",   hit_count,  32'd3);
    chk("flush_misses", miss_count, 32'd4);

    // reset after the second beat of a refill
    beats = 0;
    @(posedge clk);
    #1;
    cpu_req  = 1'b1;
    cpu_addr = 32'h80;
    guard = 0;
    while (beats < 2 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("midrst_beats", beats, 32'd2);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_wait(0, 1'b0);
    do_fetch(32'h0000_0080, 32'hA0, 5);
    @(negedge clk);
    chk("midrst_misses", miss_count, 32'd1);
    chk("midrst_hits",   hit_count,  32'd0);

    // random memory waits; stall must stay high until the response
    set_wait(0, 1'b1);
    do_fetch(32'h0000_0204, 32'hA1, -1);
    @(negedge clk);
    chk("rand_misses", miss_count, 32'd2);

    // stray rvalid while idle
    @(posedge clk);
    #1;
    spurious = 1'b1;
    @(negedge clk);
    #1;
    spurious = 1'b0;
    @(negedge clk);
    chk("spur_mem_req", {31'b0, mem_req},   32'd0);
    chk("spur_stall",   {31'b0, cpu_stall}, 32'd0);
    chk("spur_valid",   {31'b0, cpu_valid}, 32'd0);
    chk("spur_misses",  miss_count,         32'd2);
    do_fetch(32'h0000_0204, 32'hA1, 0);
    idle_cycle();
    @(negedge clk);
    chk("final_hits",   hit_count,  32'd1);
    chk("final_misses", miss_count, 32'd2);
    chk("sb_empty",     sb.size(),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/icache_line_refill.md
Name: icache_line_refill

Overview:
- Parametrised, blocking, direct-mapped instruction cache with multi-word lines.
- Sits between the fetch stage and instruction memory.
- Hits return in the same cycle. Misses stall fetch while a full line is refilled over a request/valid memory handshake.
- Supports an uncached address window, a full-cache flush, and hit/miss performance counters.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction/word width.
- INDEX_BITS, 4, log2 of line count (16 lines).
- WORDS_PER_LINE, 4, words per line; power of 2, at least 2.
- UNC_HI, 16'h1c09, an address is uncached when addr[ADDR_W-1:ADDR_W-16] == UNC_HI.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  fetch request; cpu_addr valid.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_inst  out  DATA_W  instruction; meaningful only when cpu_valid=1.
- cpu_valid  out  1  cpu_inst valid this cycle.
- cpu_stall  out  1  fetch must hold cpu_req and cpu_addr stable.
- flush  in  1  invalidate all lines.
- mem_req  out  1  beat request outstanding.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_rvalid  in  1  beat complete; mem_rdata valid.
- mem_rdata  in  DATA_W  returned word.
- hit_count  out  CNT_W  cacheable hits.
- miss_count  out  CNT_W  cacheable misses.

Behaviour:
- Address split:
  - WO = log2(WORDS_PER_LINE).
  - word = addr[WO+1:2].
  - index = addr[WO+INDEX_BITS+1:WO+2].
  - tag = the remaining upper bits.
- Storage per line: valid bit, tag, WORDS_PER_LINE data words.
- Reset:
  - all valid bits = 0; FSM goes to IDLE; counters = 0.
  - mem_req = 0, mem_addr = 0, cpu_valid = 0, cpu_stall = 0.
  - Reset mid-refill abandons the refill; the partial line stays invalid.
  - Any mem_rvalid in the cycle after reset is ignored.
- FSM states: IDLE, REFILL, UNCACHED, RESP.
- IDLE:
  - flush=1 clears all valid bits this cycle. Flush takes priority over a lookup: cpu_valid=0, cpu_stall=1 for that cycle, and no counter update.
  - Cacheable hit (cpu_req=1, not flush): cpu_inst = stored word (combinational), cpu_valid=1, cpu_stall=0, hit_count++. Stays in IDLE; zero-latency back-to-back hits are supported.
  - Cacheable miss: cpu_valid=0, cpu_stall=1 (combinational), miss_count++.
    - Latch line base address; beat counter = 0.
    - Go to REFILL; mem_req rises the next cycle.
  - Uncached request: cpu_stall=1 and go to UNCACHED. No counter change, and the cache array is not touched.
  - cpu_req=0: all outputs idle.
- REFILL:
  - mem_req=1; mem_addr = line base + 4*beat.
  - On mem_rvalid:
    - write mem_rdata into the line at word=beat.
    - if beat equals the requested word, also capture it into the response register.
    - beat++.
  - On the last beat's rvalid: set valid=1 and tag for the line, go to RESP. mem_req falls next cycle.
  - Beats are issued in order from word 0; there is no critical-word-first ordering.
  - mem_rvalid while mem_req=0 is ignored.
  - flush during REFILL is ignored (not pended).
  - cpu_stall=1 throughout.
- UNCACHED:
  - mem_req=1, mem_addr = {cpu_addr[ADDR_W-1:2], 2'b00}.
  - On mem_rvalid: capture mem_rdata into the response register, go to RESP.
  - cpu_stall=1.
- RESP (one cycle):
  - cpu_inst = response register, cpu_valid=1, cpu_stall=0, mem_req=0.
  - Return to IDLE. No counter change.
- Miss latency: miss detected in cycle 0, cpu_valid asserted in cycle WORDS_PER_LINE + 1 + total memory wait cycles.
- Counters wrap modulo 2^CNT_W.
- Refill overwrites a valid line of the same index (conflict eviction); no other lines change.

Test Plan:
- Cold miss: reset, then fetch 0x0000_0048 with a memory of 0-wait (rvalid every cycle) returning 0xA0+word.
  - mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
  - cpu_valid=1 with cpu_inst=0xA2 exactly 5 cycles after the request cycle.
  - miss_count=1.
- Line reuse: after cold miss, fetch 0x40, 0x44, 0x4C on consecutive cycles.
  - Same-cycle cpu_valid, instructions 0xA0, 0xA1, 0xA3.
  - mem_req stays 0; hit_count=3.
- Conflict eviction: fetch 0x0000_0140 (same index 4, different tag), then 0x40.
  - Both miss and trigger refills; miss_count +2.
  - Returned data matches each tag's memory contents.
- Uncached: fetch 0x1c09_0010 with memory returning 0xDEADBEEF after 3 wait cycles.
  - A single beat at 0x1c09_0010.
  - cpu_valid with 0xDEADBEEF.
  - A repeat fetch also goes to memory; counters unchanged.
- Flush plus reset mid-refill:
  - flush in IDLE followed by a fetch of a previously hit address gives a miss.
  - reset asserted after beat 2 of a refill: mem_req=0 next cycle, and a later fetch of that line misses.
- Stall hold: insert random 0-4 wait cycles per beat.
  - cpu_stall stays 1 continuously until the RESP cycle.
  - A spurious mem_rvalid in IDLE causes no state change.
